datapath: RTL and testbench

DATAPATH -- requirements
Module: datapath

---
 rtl/datapath_pkg.sv | 28 ++
 rtl/datapath_alu.sv | 50 +++++
 rtl/datapath.sv | 92 +++++++++
 tb/tb_datapath.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared definitions for the control unit and the datapath.
// Holds the ALU opcode encoding, including the NOP code, and the default
// operand width and data-memory address width.
package datapath_pkg;

  localparam int DP_DATA_WIDTH = 8;
  localparam int DP_ADDR_BITS  = 5;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_AND = 4'b0010,
    OP_OR  = 4'b0011,
    OP_XOR = 4'b0100,
    OP_NOT = 4'b0101,
    OP_SHL = 4'b0110,
    OP_SHR = 4'b0111,
    OP_INC = 4'b1000,
    OP_DEC = 4'b1001,
    OP_NOP = 4'b1111
  } opcode_e;

  // True for the opcodes that update the carry/borrow flag.
  function automatic logic op_sets_carry(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU.
// Ports:
//   A, B      operands
//   opcode    operation select (see datapath_pkg::opcode_e); unused codes pass A
//   result    wrapped DATA_WIDTH-bit result
//   carry_out carry of ADD, borrow of SUB, 0 otherwise
module alu
  import datapath_pkg::*;
#(
  parameter int DATA_WIDTH = DP_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [3:0]            opcode,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  carry_out
);

  logic [DATA_WIDTH:0] sum;
  logic [DATA_WIDTH:0] diff;

  // One extra bit so the top bit is the carry (ADD) or borrow (SUB).
  assign sum  = {1'b0, A} + {1'b0, B};
  assign diff = {1'b0, A} - {1'b0, B};

  always_comb begin
    result    = A;
    carry_out = 1'b0;
    case (opcode_e'(opcode))
      OP_ADD: begin
        result    = sum[DATA_WIDTH-1:0];
        carry_out = sum[DATA_WIDTH];
      end
      OP_SUB: begin
        result    = diff[DATA_WIDTH-1:0];
        carry_out = diff[DATA_WIDTH];
      end
      OP_AND: result = A & B;
      OP_OR:  result = A | B;
      OP_XOR: result = A ^ B;
      OP_NOT: result = ~A;
      OP_SHL: result = A << B[2:0];
      OP_SHR: result = A >> B[2:0];
      OP_INC: result = A + DATA_WIDTH'(1);
      OP_DEC: result = A - DATA_WIDTH'(1);
      default: result = A;
    endcase
  end

endmodule

// File: rtl/datapath.sv
// Datapath: ALU, registered result/flags and a 2^ADDR_BITS-word data memory.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   operand1            ALU A; base address for load/store
//   operand2            ALU B when sel3=0; store data when w_r=1
//   offset              ALU B when sel3=1
//   opcode              ALU operation
//   sel1                result source: 1 = ALU, 0 = data memory
//   sel3                ALU B source: 1 = offset, 0 = operand2
//   w_r                 data-memory write enable
//   result2             sel1_q ? alu_q : mem_q
//   zero, carry         registered ALU flags
module datapath
  import datapath_pkg::*;
#(
  parameter int DATA_WIDTH = DP_DATA_WIDTH,
  parameter int ADDR_BITS  = DP_ADDR_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] operand1,
  input  logic [DATA_WIDTH-1:0] operand2,
  input  logic [DATA_WIDTH-1:0] offset,
  input  logic [3:0]            opcode,
  input  logic                  sel1,
  input  logic                  sel3,
  input  logic                  w_r,
  output logic [DATA_WIDTH-1:0] result2,
  output logic                  zero,
  output logic                  carry
);

  localparam int MEM_DEPTH = 1 << ADDR_BITS;

  logic [DATA_WIDTH-1:0] alu_b;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  alu_carry;
  logic [ADDR_BITS-1:0]  addr;

  logic [DATA_WIDTH-1:0] alu_q;
  logic [DATA_WIDTH-1:0] mem_q;
  logic                  sel1_q;
  logic                  zero_q;
  logic                  carry_q;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  assign alu_b = sel3 ? offset : operand2;

  alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .A         (operand1),
    .B         (alu_b),
    .opcode    (opcode),
    .result    (alu_res),
    .carry_out (alu_carry)
  );

  // Upper ALU bits are dropped, so addresses wrap around the memory.
  assign addr = alu_res[ADDR_BITS-1:0];

  // Execute / memory stage: everything registers on the same edge. The memory
  // read uses the pre-write contents, so a same-address store returns the old
  // word. Reset preloads mem[i] = i and blocks any write on that edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_q   <= '0;
      mem_q   <= '0;
      sel1_q  <= 1'b0;
      zero_q  <= 1'b1;
      carry_q <= 1'b0;
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem[i] <= DATA_WIDTH'(i);
      end
    end else begin
      alu_q  <= alu_res;
      sel1_q <= sel1;
      zero_q <= (alu_res == '0);
      if (op_sets_carry(opcode)) begin
        carry_q <= alu_carry;
      end
      mem_q <= mem[addr];
      if (w_r) begin
        mem[addr] <= operand2;
      end
    end
  end

  // Write-back select
  assign result2 = sel1_q ? alu_q : mem_q;
  assign zero    = zero_q;
  assign carry   = carry_q;

endmodule

// File: tb/tb_datapath.sv
module tb_datapath;
  import datapath_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] operand1, operand2, offset;
  logic [3:0] opcode;
  logic       sel1, sel3, w_r;
  logic [7:0] result2;
  logic       zero, carry;

  int checks   = 0;
  int failures = 0;

  // Reference state, written directly from the behavioural rules.
  int m_mem [32];
  int m_alu, m_memq, m_zero, m_carry, m_sel1;

  datapath #(.DATA_WIDTH(8), .ADDR_BITS(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .operand1 (operand1),
    .operand2 (operand2),
    .offset   (offset),
    .opcode   (opcode),
    .sel1     (sel1),
    .sel3     (sel3),
    .w_r      (w_r),
    .result2  (result2),
    .zero     (zero),
    .carry    (carry)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a, b, off;
    logic [3:0] op;
    logic       s3;
    logic [7:0] exp_r;
    logic       exp_z, exp_c;
  } vec_t;

  vec_t vecs [$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Result value and carry flag of one ALU operation, in integer arithmetic.
  task automatic ref_alu(input int a, input int b, input int op,
                         output int r, output int c, output bit sets_c);
    sets_c = 0;
    c = 0;
    case (op)
      0:  begin r = (a + b) % 256; c = (a + b) > 255 ? 1 : 0; sets_c = 1; end
      1:  begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0; sets_c = 1; end
      2:  r = a & b;
      3:  r = a | b;
      4:  r = a ^ b;
      5:  r = 255 - a;
      6:  r = (a * (1 << (b % 8))) % 256;
      7:  r = a / (1 << (b % 8));
      8:  r = (a + 1) % 256;
      9:  r = (a + 255) % 256;
      default: r = a;
    endcase
  endtask

  task automatic model_edge();
    int r, c, addr;
    bit sc;
    if (rst) begin
      m_alu = 0; m_memq = 0; m_sel1 = 0; m_zero = 1; m_carry = 0;
      for (int i = 0; i < 32; i++) m_mem[i] = i;
    end else begin
      ref_alu(int'(operand1), sel3 ? int'(offset) : int'(operand2), int'(opcode), r, c, sc);
      addr   = r % 32;
      m_memq = m_mem[addr];
      if (w_r) m_mem[addr] = int'(operand2);
      m_alu  = r;
      m_sel1 = int'(sel1);
      m_zero = (r == 0) ? 1 : 0;
      if (sc) m_carry = c;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic [7:0] a, b, off, input logic [3:0] op,
                       input logic s1, s3, wr, r);
    operand1 = a; operand2 = b; offset = off; opcode = op;
    sel1 = s1; sel3 = s3; w_r = wr; rst = r;
  endtask

  task automatic do_reset();
    drive(8'h00, 8'h00, 8'h00, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1);
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    drive(8'h00, 8'h00, 8'h00, 4'hF, 1'b1, 1'b0, 1'b1, 1'b1);
    #2;
    tick(); tick();
    chk("reset_result2", int'(result2), 0);
    chk("reset_zero", int'(zero), 1);
    chk("reset_carry", int'(carry), 0);
    rst = 1'b0;

    vecs.push_back('{8'h05, 8'h03, 8'h00, 4'h0, 1'b0, 8'h08, 1'b0, 1'b0});
    vecs.push_back('{8'hF0, 8'h20, 8'h00, 4'h0, 1'b0, 8'h10, 1'b0, 1'b1});
    vecs.push_back('{8'h03, 8'h03, 8'h00, 4'h1, 1'b0, 8'h00, 1'b1, 1'b0});
    vecs.push_back('{8'h03, 8'h05, 8'h00, 4'h1, 1'b0, 8'hFE, 1'b0, 1'b1});
    vecs.push_back('{8'hC3, 8'h5A, 8'h00, 4'h2, 1'b0, 8'h42, 1'b0, 1'b1});
    vecs.push_back('{8'hC3, 8'h5A, 8'h00, 4'h3, 1'b0, 8'hDB, 1'b0, 1'b1});
    vecs.push_back('{8'hC3, 8'h5A, 8'h00, 4'h4, 1'b0, 8'h99, 1'b0, 1'b1});
    vecs.push_back('{8'h0F, 8'h00, 8'h00, 4'h5, 1'b0, 8'hF0, 1'b0, 1'b1});
    vecs.push_back('{8'h81, 8'h0B, 8'h00, 4'h6, 1'b0, 8'h08, 1'b0, 1'b1});
    vecs.push_back('{8'h81, 8'h0B, 8'h00, 4'h7, 1'b0, 8'h10, 1'b0, 1'b1});
    vecs.push_back('{8'hFF, 8'h00, 8'h00, 4'h8, 1'b0, 8'h00, 1'b1, 1'b1});
    vecs.push_back('{8'h00, 8'h00, 8'h00, 4'h9, 1'b0, 8'hFF, 1'b0, 1'b1});
    vecs.push_back('{8'h37, 8'h12, 8'h00, 4'hF, 1'b0, 8'h37, 1'b0, 1'b1});
    vecs.push_back('{8'h5C, 8'h12, 8'h00, 4'hA, 1'b0, 8'h5C, 1'b0, 1'b1});
    vecs.push_back('{8'h10, 8'h99, 8'h20, 4'h0, 1'b1, 8'h30, 1'b0, 1'b0});

    foreach (vecs[k]) begin
      drive(vecs[k].a, vecs[k].b, vecs[k].off, vecs[k].op, 1'b1, vecs[k].s3, 1'b0, 1'b0);
      tick();
      chk($sformatf("vec%0d_result2", k), int'(result2), int'(vecs[k].exp_r));
      chk($sformatf("vec%0d_zero", k), int'(zero), int'(vecs[k].exp_z));
      chk($sformatf("vec%0d_carry", k), int'(carry), int'(vecs[k].exp_c));
    end

    // Held inputs keep result2 steady.
    tick(); tick();
    chk("hold_result2", int'(result2), 8'h30);

    // Load 2+5 -> mem[7].
    do_reset();
    drive(8'h02, 8'h00, 8'h05, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(); tick();
    chk("load_mem7", int'(result2), 7);

    // Store AA at 1+3, then load it back.
    drive(8'h01, 8'hAA, 8'h03, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    w_r = 1'b0;
    tick(); tick();
    chk("store_load_AA", int'(result2), 8'hAA);

    // Same-cycle store+load at address 4 after reset returns the old word.
    do_reset();
    drive(8'h00, 8'h55, 8'h04, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    chk("rd_first_old", int'(result2), 4);
    w_r = 1'b0;
    tick();
    chk("rd_after_wr", int'(result2), 8'h55);

    // 30+5 wraps to address 3.
    drive(8'd30, 8'h00, 8'd5, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(); tick();
    chk("addr_wrap", int'(result2), 3);

    // A store on a reset edge is dropped and an in-flight ALU result is cleared.
    drive(8'h40, 8'h01, 8'h00, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(8'h00, 8'hEE, 8'h09, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    chk("rst_mid_result2", int'(result2), 0);
    chk("rst_mid_zero", int'(zero), 1);
    rst = 1'b0; w_r = 1'b0;
    tick(); tick();
    chk("rst_store_dropped", int'(result2), 9);

    // Random traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      drive(8'($urandom), 8'($urandom), 8'($urandom),
            ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9)),
            1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 31) == 0));
      tick();
      chk($sformatf("rnd%0d_result2", n), int'(result2), m_sel1 ? m_alu : m_memq);
      chk($sformatf("rnd%0d_zero", n), int'(zero), m_zero);
      chk($sformatf("rnd%0d_carry", n), int'(carry), m_carry);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
